vx_csr_warp_fence: RTL and testbench
====================================

VX_CSR_WARP_FENCE -- requirements
Module: vx_csr_warp_fence

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: number of warps tracked; NW_WIDTH = max(1, clog2(NUM_WARPS)).
REQ-002 SHALL have parameter CNT_WIDTH, default 4: width of each per-warp pending-instruction counter.
REQ-003 SHALL have parameter CYCLE_WIDTH, default 64: width of the cycle counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 issue_valid / issue_wid  input  1 / NW_WIDTH  one instruction of warp issue_wid enters the pipeline.
REQ-008 commit_valid / commit_wid  input  1 / NW_WIDTH  one instruction of warp commit_wid retires.
REQ-009 lock_valid / lock_wid  input  1 / NW_WIDTH  FPU-CSR instruction issued; lock that warp.
REQ-010 unlock_warp / unlock_wid  input  1 / NW_WIDTH  CSR unit has accepted the last packet; unlock that warp.
REQ-011 alm_empty_wid  input  NW_WIDTH  warp queried by the CSR unit.
REQ-012 alm_empty  output  1  queried warp has at most one instruction in flight.
REQ-013 locked_mask  output  NUM_WARPS  bit w = warp w is locked; scheduler must not issue it.
REQ-014 cycles  output  CYCLE_WIDTH  free-running cycle count.
REQ-015 lock_cycles  output  32  cycles with any warp locked (see Configuration).
REQ-016 err  output  1  sticky protocol error flag.

Function
REQ-017 Per-warp counter pending[w] SHALL be +1 on issue to w, -1 on commit to w, unchanged when both target w in the same cycle.
REQ-018 pending[w] SHALL saturate at 2^CNT_WIDTH-1 on issue and set err (overflow).
REQ-019 Commit to w while pending[w]==0 SHALL leave pending[w] at 0 and set err (underflow).
REQ-020 alm_empty SHALL be combinational: (pending[alm_empty_wid] <= 1), computed from registered counters only; same-cycle issue/commit is not visible until the next cycle.
REQ-021 Each warp SHALL have a two-state lock FSM: UNLOCKED -> LOCKED on lock_valid for w; LOCKED -> UNLOCKED on unlock_warp for w.
REQ-022 lock_valid to an already LOCKED warp SHALL set err; the warp stays LOCKED.
REQ-023 unlock_warp to an UNLOCKED warp SHALL set err; the warp stays UNLOCKED.
REQ-024 Simultaneous unlock and lock of the same warp SHALL apply unlock then lock: final state LOCKED, no err.
REQ-025 locked_mask SHALL be registered FSM state; it takes effect the cycle after lock_valid.
REQ-026 Events for different warps in the same cycle SHALL all apply independently.
REQ-027 cycles SHALL increment by 1 every cycle after reset and wrap from all-ones to 0.
REQ-028 err SHALL remain 1 once set, until reset.
REQ-029 Out-of-range wid values (>= NUM_WARPS) SHALL be ignored and SHALL set err.

Reset
REQ-030 Asserting reset SHALL, asynchronously, clear all pending counters, put all warps in UNLOCKED, and clear cycles, lock_cycles and err.
REQ-031 Consequently, during and right after reset, alm_empty = 1 and locked_mask = 0.
REQ-032 Events presented while reset is high SHALL be discarded.
REQ-033 A reset mid-lock SHALL release the warp with no err.

Configuration
REQ-034 Macro VX_CSR_LOCK_PERF_EN SHALL control the lock_cycles counter.
REQ-035 With VX_CSR_LOCK_PERF_EN defined, lock_cycles SHALL increment in each cycle where locked_mask != 0, saturating at all-ones.
REQ-036 Without VX_CSR_LOCK_PERF_EN, lock_cycles SHALL be tied to 0 and no counter logic SHALL be synthesized; the port remains present.

Verification
REQ-037 Three issues to w1 over three cycles, then alm_empty_wid=1: alm_empty=0. Then two commits to w1: alm_empty=1 (pending=1).
REQ-038 Issue and commit to w2 in the same cycle with pending[2]=1: pending stays 1 and err=0.
REQ-039 lock_valid w3 at cycle t: locked_mask=4'b1000 at t+1. Then unlock_warp w3: locked_mask=0 the next cycle; with the macro, lock_cycles equals the locked duration.
REQ-040 Commit to w0 with pending=0, then 16 issues to w0 with CNT_WIDTH=4: err=1 and pending[0]=15.
REQ-041 Unlock and lock of w1 in the same cycle: w1 LOCKED, err=0. Then a second lock of w1: err=1.
REQ-042 With w2 locked and pending=5, assert reset for 1 cycle: locked_mask=0, alm_empty=1, cycles=0, err=0.

Source files
------------

// File: rtl/vx_csr_warp_fence.sv
// Per-warp pending-instruction counters and FPU-CSR lock FSMs feeding the warp scheduler.
// Optional lock_cycles perf counter enabled by defining VX_CSR_LOCK_PERF_EN.

module vx_csr_warp_fence_slot #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic                 commit,
  input  logic                 lock,
  input  logic                 unlock,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 locked,
  output logic                 err
);
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e state_q, state_d;
  logic        lock_err;

  wire inc = issue & ~commit;
  wire dec = commit & ~issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pending <= '0;
    else if (inc && !(&pending)) pending <= pending + 1'b1;
    else if (dec && (|pending))  pending <= pending - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= UNLOCKED;
    else       state_q <= state_d;
  end

  // Same-cycle unlock+lock is treated as unlock followed by lock.
  always_comb begin
    state_d  = state_q;
    lock_err = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (unlock) lock_err = 1'b1;
        if (lock)   state_d  = LOCKED;
      end
      LOCKED: begin
        if (lock && !unlock)      lock_err = 1'b1;
        else if (unlock && !lock) state_d  = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign locked = (state_q == LOCKED);
  assign err    = (inc & (&pending)) | (dec & ~(|pending)) | lock_err;
endmodule

module vx_csr_warp_fence #(
  parameter int NUM_WARPS   = 4,
  parameter int CNT_WIDTH   = 4,
  parameter int CYCLE_WIDTH = 64,
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [NW_WIDTH-1:0]    issue_wid,
  input  logic                   commit_valid,
  input  logic [NW_WIDTH-1:0]    commit_wid,
  input  logic                   lock_valid,
  input  logic [NW_WIDTH-1:0]    lock_wid,
  input  logic                   unlock_warp,
  input  logic [NW_WIDTH-1:0]    unlock_wid,
  input  logic [NW_WIDTH-1:0]    alm_empty_wid,
  output logic                   alm_empty,
  output logic [NUM_WARPS-1:0]   locked_mask,
  output logic [CYCLE_WIDTH-1:0] cycles,
  output logic [31:0]            lock_cycles,
  output logic                   err
);
  function automatic logic in_range(input logic [NW_WIDTH-1:0] wid);
    return 32'(wid) < NUM_WARPS;
  endfunction

  logic [NUM_WARPS-1:0][CNT_WIDTH-1:0] pending;
  logic [NUM_WARPS-1:0]                slot_err;
  logic                                oor_err;
  logic [CNT_WIDTH-1:0]                ae_cnt;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    vx_csr_warp_fence_slot #(.CNT_WIDTH(CNT_WIDTH)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .issue   (issue_valid  && (issue_wid  == NW_WIDTH'(w))),
      .commit  (commit_valid && (commit_wid == NW_WIDTH'(w))),
      .lock    (lock_valid   && (lock_wid   == NW_WIDTH'(w))),
      .unlock  (unlock_warp  && (unlock_wid == NW_WIDTH'(w))),
      .pending (pending[w]),
      .locked  (locked_mask[w]),
      .err     (slot_err[w])
    );
  end

  // Out-of-range events never match a slot, so they are dropped; only flag them.
  assign oor_err = (issue_valid  & ~in_range(issue_wid))
                 | (commit_valid & ~in_range(commit_wid))
                 | (lock_valid   & ~in_range(lock_wid))
                 | (unlock_warp  & ~in_range(unlock_wid));

  // An unqualified out-of-range query reads as empty rather than raising err.
  assign ae_cnt    = in_range(alm_empty_wid) ? pending[alm_empty_wid] : '0;
  assign alm_empty = (ae_cnt <= CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      err <= 1'b0;
    else if ((|slot_err) | oor_err) err <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 1'b1;
  end

`ifdef VX_CSR_LOCK_PERF_EN
  logic [31:0] lock_cycles_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   lock_cycles_q <= '0;
    else if ((|locked_mask) && !(&lock_cycles_q)) lock_cycles_q <= lock_cycles_q + 1'b1;
  end
  assign lock_cycles = lock_cycles_q;
`else
  assign lock_cycles = '0;
`endif
endmodule

// File: tb/tb_vx_csr_warp_fence.sv
// Randomized + directed bench for vx_csr_warp_fence with a queue scoreboard and behavioural model.
module tb_vx_csr_warp_fence;
  localparam int NW  = 4;
  localparam int NWW = 2;
  localparam int PMAX = 15;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           issue_valid = 1'b0, commit_valid = 1'b0, lock_valid = 1'b0, unlock_warp = 1'b0;
  logic [NWW-1:0] issue_wid = '0, commit_wid = '0, lock_wid = '0, unlock_wid = '0, alm_empty_wid = '0;
  logic           alm_empty;
  logic [NW-1:0]  locked_mask;
  logic [63:0]    cycles;
  logic [31:0]    lock_cycles;
  logic           err;

  vx_csr_warp_fence #(.NUM_WARPS(NW), .CNT_WIDTH(4), .CYCLE_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wid(issue_wid),
    .commit_valid(commit_valid), .commit_wid(commit_wid),
    .lock_valid(lock_valid), .lock_wid(lock_wid),
    .unlock_warp(unlock_warp), .unlock_wid(unlock_wid),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
    .locked_mask(locked_mask), .cycles(cycles), .lock_cycles(lock_cycles), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ae;
    logic [3:0]  lm;
    logic [63:0] cyc;
    logic [31:0] lc;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: counts per warp, lock flags, sticky error, counters.
  int              m_pend[NW];
  bit              m_lock[NW];
  bit              m_err;
  longint unsigned m_cyc;
  int unsigned     m_lc;

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin m_pend[w] = 0; m_lock[w] = 0; end
    m_err = 0; m_cyc = 0; m_lc = 0;
  endfunction

  function automatic void model_update(input bit iv, input int iw, input bit cv, input int cw,
                                       input bit lv, input int lw, input bit uv, input int uw);
    bit any_locked = 0;
    for (int w = 0; w < NW; w++) any_locked |= m_lock[w];
`ifdef VX_CSR_LOCK_PERF_EN
    if (any_locked && m_lc != 32'hFFFF_FFFF) m_lc++;
`endif
    m_cyc++;
    for (int w = 0; w < NW; w++) begin
      int net = ((iv && iw == w) ? 1 : 0) - ((cv && cw == w) ? 1 : 0);
      if (net > 0) begin
        if (m_pend[w] == PMAX) m_err = 1; else m_pend[w]++;
      end else if (net < 0) begin
        if (m_pend[w] == 0) m_err = 1; else m_pend[w]--;
      end
      if (uv && uw == w) begin
        if (!m_lock[w]) m_err = 1;
        m_lock[w] = 0;
      end
      if (lv && lw == w) begin
        if (m_lock[w]) m_err = 1;
        m_lock[w] = 1;
      end
    end
  endfunction

  // ev = {unlock, lock, commit, issue}
  task automatic step(input bit rs, input logic [3:0] ev, input int iw, input int cw,
                      input int lw, input int uw, input int aw);
    exp_t e;
    @(posedge clk); #1;
    reset = rs;
    issue_valid = ev[0];  issue_wid  = NWW'(iw);
    commit_valid = ev[1]; commit_wid = NWW'(cw);
    lock_valid = ev[2];   lock_wid   = NWW'(lw);
    unlock_warp = ev[3];  unlock_wid = NWW'(uw);
    alm_empty_wid = NWW'(aw);
    if (rs) model_reset();
    e.ae = (m_pend[aw] <= 1);
    e.lm = '0;
    for (int w = 0; w < NW; w++) e.lm[w] = m_lock[w];
    e.cyc = m_cyc; e.lc = m_lc; e.er = m_err;
    sb.push_back(e);
    if (!rs) model_update(ev[0], iw, ev[1], cw, ev[2], lw, ev[3], uw);
  endtask

  task automatic idle(input int aw);
    step(0, 4'b0000, 0, 0, 0, 0, aw);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("alm_empty",   64'(alm_empty),   64'(e.ae));
      chk("locked_mask", 64'(locked_mask), 64'(e.lm));
      chk("cycles",      cycles,           e.cyc);
      chk("lock_cycles", 64'(lock_cycles), 64'(e.lc));
      chk("err",         64'(err),         64'(e.er));
    end
  end

  initial begin
    model_reset();
    step(1, 4'b0000, 0, 0, 0, 0, 0);
    step(1, 4'b1111, 1, 2, 3, 0, 1);   // events during reset are dropped
    // three issues to w1, then two commits
    repeat (3) step(0, 4'b0001, 1, 0, 0, 0, 1);
    idle(1);
    repeat (2) step(0, 4'b0010, 0, 1, 0, 0, 1);
    idle(1);
    // issue+commit same cycle on w2
    step(0, 4'b0001, 2, 0, 0, 0, 2);
    step(0, 4'b0011, 2, 2, 0, 0, 2);
    idle(2); idle(2);
    // lock w3 for a few cycles
    step(0, 4'b0100, 0, 0, 3, 0, 0);
    repeat (3) idle(0);
    step(0, 4'b1000, 0, 0, 0, 3, 0);
    idle(0); idle(0);
    // unlock+lock w1 together, then double lock
    step(0, 4'b0100, 0, 0, 1, 0, 0);
    idle(0);
    step(0, 4'b1100, 0, 0, 1, 1, 0);
    idle(0);
    step(0, 4'b0100, 0, 0, 1, 0, 0);
    idle(0);
    // underflow on w0 then saturate it
    step(1, 4'b0000, 0, 0, 0, 0, 0);
    step(0, 4'b0010, 0, 0, 0, 0, 0);
    repeat (16) step(0, 4'b0001, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    // reset mid-lock with pending work
    step(1, 4'b0000, 0, 0, 0, 0, 2);
    step(0, 4'b0100, 0, 0, 2, 0, 2);
    repeat (5) step(0, 4'b0001, 2, 0, 0, 0, 2);
    idle(2);
    step(1, 4'b0000, 0, 0, 0, 0, 2);
    idle(2); idle(2);
    // random traffic with periodic resets to clear sticky err
    for (int i = 0; i < 800; i++) begin
      logic [3:0] ev;
      bit rs;
      ev[0] = ($urandom % 2) == 0;
      ev[1] = ($urandom % 2) == 0;
      ev[2] = ($urandom % 6) == 0;
      ev[3] = ($urandom % 6) == 0;
      rs = (i % 100 == 0) || (($urandom % 150) == 0);
      step(rs, ev, $urandom % NW, $urandom % NW, $urandom % NW, $urandom % NW, $urandom % NW);
    end
    idle(0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
